// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels byte requests from NUM_REQ sources onto one
// UART tx line, framing each accepted byte as 8N1 and stepping on baud_tick.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   baud_tick,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d;

    logic [7:0]      req_bytes [NUM_REQ];
    logic            found;
    logic [ID_W-1:0] winner;
    logic            accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // Search ascends from the requester after the previous winner, with wrap.
    always_comb begin : arbiter
        int              idx;
        logic [ID_W-1:0] idx_w;
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        found     = 1'b0;
        winner    = '0;
        idx       = 0;
        idx_w     = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(last_grant_q) + 1 + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
        accept = !reset && found &&
                 (state_q == S_IDLE || (state_q == S_STOP && baud_tick));
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        data_d       = data_q;
        tx_d         = tx_q;

        if (accept) begin
            data_d       = req_bytes[winner];
            last_grant_d = winner;
            grant_id_d   = winner;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                // Waits for the first tick strictly after the accept cycle.
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d      = data_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = data_q[bit_cnt_q + 3'd1];
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (accept) begin
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            // NOTE: the byte register is cleared too, so an aborted frame leaves no stale data.
            data_q       <= 8'h00;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            data_q       <= data_d;
            tx_q         <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;

endmodule
